vedic_mul_arbiter: RTL and testbench
====================================

Name: vedic_mul_arbiter

Overview:
- Shares one combinational `vedic_32x32` multiplier (ports a, b, y; 64-bit unsigned product) between two requesters.
- Round-robin arbitration across the two requesters.
- Treats the multiplier as a multicycle path: operands are held stable for MUL_CYCLES clocks, then the product is registered.
- Returns the result on a single tagged response channel with valid/ready handshake.

Parameters:
- MUL_CYCLES, 2, clocks the operands are held before y is sampled; legal range 1..15.
- CNT_W, 4, width of the internal settle counter; must satisfy 2^CNT_W > MUL_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has operands.
- req0_ready  out  1  requester 0 operands accepted this cycle.
- req0_a  in  32  requester 0 multiplicand.
- req0_b  in  32  requester 0 multiplier.
- req1_valid, req1_ready, req1_a, req1_b  same as above, for requester 1.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer takes product.
- rsp_id  out  1  index of the requester that owns rsp_y.
- rsp_y  out  64  registered product a*b, unsigned.

Behaviour:
- Reset values (asynchronous, while rst=1):
  - state=IDLE, rsp_valid=0, rsp_id=0, rsp_y=0.
  - Operand registers=0, counter=0, last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - grant = the only valid requester. If both are valid, grant = !last_grant.
  - reqN_ready = (state==IDLE) && reqN_valid && grant==N. It is combinational and never asserted outside IDLE.
  - On accept (valid&&ready):
    - latch a/b into op_a/op_b and the id into cur_id;
    - last_grant <= id;
    - counter <= MUL_CYCLES-1;
    - go to CALC.
  - No valid requester: stay in IDLE; last_grant is unchanged.
- CALC:
  - The multiplier inputs are driven only from op_a/op_b, so they are stable throughout CALC.
  - counter decrements each clock.
  - When counter==0: rsp_y <= y, rsp_id <= cur_id, rsp_valid <= 1, go to DONE.
- DONE:
  - rsp_valid=1; rsp_y and rsp_id are held stable while !rsp_ready.
  - On rsp_ready: rsp_valid <= 0 and go to IDLE.
  - The next accept is the following cycle at the earliest.
- Latency and throughput:
  - Accept at edge N, rsp_valid high after edge N+MUL_CYCLES.
  - With rsp_ready tied high, one product per MUL_CYCLES+2 clocks.
- Boundary conditions:
  - Requester drops valid without being accepted: no effect, and the grant is not sticky.
  - Requester operands changing after accept: ignored.
  - rst asserted mid-CALC or mid-DONE: the operation is aborted, all outputs return to reset values, and no response is issued.
  - Product width: the full 64 bits, no truncation.
  - 0xFFFFFFFF*0xFFFFFFFF must equal 0xFFFFFFFE00000001.
- MUL_CYCLES=1: CALC lasts exactly one clock.

Optional Feature:
- Macro: VEDIC_MUL_ARBITER_STATS_EN.
- Defined:
  - Extra outputs gnt0_cnt and gnt1_cnt, 16 bits each.
  - Each counts accepts for its requester, saturates at 0xFFFF, and is cleared by rst.
  - Extra input stats_clr, 1 bit, synchronous clear of both counters. If stats_clr and an accept occur in the same cycle, the result is 0 (clear wins).
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Single request, MUL_CYCLES=2:
  - Stimulus: req0 a=1, b=3.
  - Response: req0_ready for 1 cycle; rsp_valid 2 clocks after accept; rsp_y=3, rsp_id=0.
- Simultaneous requests, rsp_ready=1:
  - Stimulus: req0 85*102 and req1 204*221 both valid from reset.
  - Response: first rsp_id=0 with rsp_y=8670, then rsp_id=1 with rsp_y=45084.
  - Re-present both: requester 0 wins again, because last_grant=1.
- Starvation check:
  - Stimulus: req0 and req1 held valid for 6 transactions.
  - Response: rsp_id sequence 0,1,0,1,0,1.
  - Products: 238*119=28322 for req0 and 255*85=21675 for req1.
- Backpressure:
  - Stimulus: 170*170 with rsp_ready=0 for 5 cycles.
  - Response: rsp_valid stays 1 and rsp_y stays 28900; no reqN_ready during the stall; response completes on rsp_ready.
- Max operands and operand hold:
  - Stimulus: a=b=0xFFFFFFFF; during CALC, change req0_a to 0.
  - Response: rsp_y=0xFFFFFFFE00000001.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle during CALC of 85*221.
  - Response: rsp_valid=0 immediately and no stale response appears.
  - After release, a tie grants requester 0 first.
  - With VEDIC_MUL_ARBITER_STATS_EN defined: counters read 0 after rst.

Source files
------------

// File: rtl/vedic_mul_arbiter_if.sv
// Operand and response bundle for vedic_mul_arbiter: two requesters and one tagged product channel.
// The master modport is the requester/consumer side and the slave modport is the arbiter.
interface vedic_mul_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [63:0] rsp_y;

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_y,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_y,
    input  rsp_ready
  );
endinterface

// File: rtl/vedic_mul_arbiter.sv
// Round-robin arbiter sharing one combinational Vedic 32x32 multiplier, sampled as a MUL_CYCLES multicycle path.
// Optional grant statistics (gnt0/gnt1 counters, stats_clr) are built when VEDIC_MUL_ARBITER_STATS_EN is defined.

module vedic_2x2 (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic [3:0] o_y
);
  logic w_p00, w_p01, w_p10, w_p11, w_c1;

  assign w_p00 = i_a[0] & i_b[0];
  assign w_p01 = i_a[0] & i_b[1];
  assign w_p10 = i_a[1] & i_b[0];
  assign w_p11 = i_a[1] & i_b[1];
  // Urdhva-Tiryagbhyam base: vertical and crosswise products folded with half adders.
  assign w_c1  = w_p01 & w_p10;
  assign o_y   = {w_p11 & w_c1, w_p11 ^ w_c1, w_p01 ^ w_p10, w_p00};
endmodule

module vedic_4x4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_y
);
  logic [3:0] w_ll, w_lh, w_hl, w_hh;
  logic [4:0] w_mid;

  vedic_2x2 u_ll (.i_a(i_a[1:0]), .i_b(i_b[1:0]), .o_y(w_ll));
  vedic_2x2 u_lh (.i_a(i_a[1:0]), .i_b(i_b[3:2]), .o_y(w_lh));
  vedic_2x2 u_hl (.i_a(i_a[3:2]), .i_b(i_b[1:0]), .o_y(w_hl));
  vedic_2x2 u_hh (.i_a(i_a[3:2]), .i_b(i_b[3:2]), .o_y(w_hh));

  assign w_mid = {1'b0, w_lh} + {1'b0, w_hl};
  assign o_y   = {w_hh, w_ll} + {1'b0, w_mid, 2'b00};
endmodule

module vedic_8x8 (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_y
);
  logic [7:0] w_ll, w_lh, w_hl, w_hh;
  logic [8:0] w_mid;

  vedic_4x4 u_ll (.i_a(i_a[3:0]), .i_b(i_b[3:0]), .o_y(w_ll));
  vedic_4x4 u_lh (.i_a(i_a[3:0]), .i_b(i_b[7:4]), .o_y(w_lh));
  vedic_4x4 u_hl (.i_a(i_a[7:4]), .i_b(i_b[3:0]), .o_y(w_hl));
  vedic_4x4 u_hh (.i_a(i_a[7:4]), .i_b(i_b[7:4]), .o_y(w_hh));

  assign w_mid = {1'b0, w_lh} + {1'b0, w_hl};
  assign o_y   = {w_hh, w_ll} + {3'd0, w_mid, 4'd0};
endmodule

module vedic_16x16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [31:0] o_y
);
  logic [15:0] w_ll, w_lh, w_hl, w_hh;
  logic [16:0] w_mid;

  vedic_8x8 u_ll (.i_a(i_a[7:0]),  .i_b(i_b[7:0]),  .o_y(w_ll));
  vedic_8x8 u_lh (.i_a(i_a[7:0]),  .i_b(i_b[15:8]), .o_y(w_lh));
  vedic_8x8 u_hl (.i_a(i_a[15:8]), .i_b(i_b[7:0]),  .o_y(w_hl));
  vedic_8x8 u_hh (.i_a(i_a[15:8]), .i_b(i_b[15:8]), .o_y(w_hh));

  assign w_mid = {1'b0, w_lh} + {1'b0, w_hl};
  assign o_y   = {w_hh, w_ll} + {7'd0, w_mid, 8'd0};
endmodule

module vedic_32x32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] y
);
  logic [31:0] w_ll, w_lh, w_hl, w_hh;
  logic [32:0] w_mid;

  vedic_16x16 u_ll (.i_a(a[15:0]),  .i_b(b[15:0]),  .o_y(w_ll));
  vedic_16x16 u_lh (.i_a(a[15:0]),  .i_b(b[31:16]), .o_y(w_lh));
  vedic_16x16 u_hl (.i_a(a[31:16]), .i_b(b[15:0]),  .o_y(w_hl));
  vedic_16x16 u_hh (.i_a(a[31:16]), .i_b(b[31:16]), .o_y(w_hh));

  assign w_mid = {1'b0, w_lh} + {1'b0, w_hl};
  assign y     = {w_hh, w_ll} + {15'd0, w_mid, 16'd0};
endmodule

module vedic_mul_arbiter #(
  parameter int MUL_CYCLES = 2,
  parameter int CNT_W      = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  vedic_mul_arbiter_if.slave  bus
`ifdef VEDIC_MUL_ARBITER_STATS_EN
  ,
  input  logic                i_stats_clr,
  output logic [15:0]         o_gnt0_cnt,
  output logic [15:0]         o_gnt1_cnt
`endif
);
  // state  | meaning
  // S_IDLE | waiting for a requester; grant and ready are combinational here only
  // S_CALC | op_a/op_b held on the multiplier while the settle counter runs down
  // S_DONE | product registered, rsp_valid high until rsp_ready
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_grant;
  logic             r_cur_id;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [63:0]      r_rsp_y;

  logic             w_idle;
  logic             w_grant;
  logic             w_accept;
  logic [63:0]      w_y;

  assign w_idle = (r_state == S_IDLE);

  always_comb begin
    w_grant = ~r_last_grant;
    if (bus.req0_valid && !bus.req1_valid) begin
      w_grant = 1'b0;
    end else if (bus.req1_valid && !bus.req0_valid) begin
      w_grant = 1'b1;
    end
  end

  assign bus.req0_ready = w_idle && bus.req0_valid && !w_grant;
  assign bus.req1_ready = w_idle && bus.req1_valid && w_grant;
  assign w_accept       = bus.req0_ready || bus.req1_ready;

  // Multiplier sees only the operand registers, so its inputs cannot move during CALC.
  vedic_32x32 u_mul (
    .a (r_op_a),
    .b (r_op_b),
    .y (w_y)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_cur_id     <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_y      <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op_a       <= w_grant ? bus.req1_a : bus.req0_a;
            r_op_b       <= w_grant ? bus.req1_b : bus.req0_b;
            r_cur_id     <= w_grant;
            r_last_grant <= w_grant;
            r_cnt        <= CNT_W'(MUL_CYCLES - 1);
            r_state      <= S_CALC;
          end
        end
        S_CALC: begin
          if (r_cnt == '0) begin
            r_rsp_y     <= w_y;
            r_rsp_id    <= r_cur_id;
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_y     = r_rsp_y;

`ifdef VEDIC_MUL_ARBITER_STATS_EN
  logic [15:0] r_gnt0_cnt;
  logic [15:0] r_gnt1_cnt;

  // Clear takes priority over a coincident accept.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gnt0_cnt <= '0;
      r_gnt1_cnt <= '0;
    end else if (i_stats_clr) begin
      r_gnt0_cnt <= '0;
      r_gnt1_cnt <= '0;
    end else begin
      if (bus.req0_ready && (r_gnt0_cnt != 16'hFFFF)) begin
        r_gnt0_cnt <= r_gnt0_cnt + 16'd1;
      end
      if (bus.req1_ready && (r_gnt1_cnt != 16'hFFFF)) begin
        r_gnt1_cnt <= r_gnt1_cnt + 16'd1;
      end
    end
  end

  assign o_gnt0_cnt = r_gnt0_cnt;
  assign o_gnt1_cnt = r_gnt1_cnt;
`endif
endmodule

// File: tb/tb_vedic_mul_arbiter.sv
// Randomized self-checking bench for vedic_mul_arbiter against a round-robin / plain-arithmetic reference.
// Stats checks are included when VEDIC_MUL_ARBITER_STATS_EN is defined.
module tb_vedic_mul_arbiter;
  localparam int MUL_CYCLES = 2;

  logic clk = 1'b0;
  logic rst;
  vedic_mul_arbiter_if bus();
`ifdef VEDIC_MUL_ARBITER_STATS_EN
  logic        stats_clr;
  logic [15:0] gnt0_cnt;
  logic [15:0] gnt1_cnt;
`endif

  vedic_mul_arbiter #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
`ifdef VEDIC_MUL_ARBITER_STATS_EN
    ,
    .i_stats_clr (stats_clr),
    .o_gnt0_cnt  (gnt0_cnt),
    .o_gnt1_cnt  (gnt1_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int m_last = 1;  // reference: requester granted most recently

  function automatic int exp_winner(input bit v0, input bit v1, input int last);
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    return 1 - last;
  endfunction

  // Presents one request set, holds junk on both requesters afterwards, optionally stalls the response.
  task automatic run_txn(input bit v0, input bit v1,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input int stall, input bit scramble,
                         output int who, output int lat, output logic id, output logic [63:0] y,
                         output bit stable, output bit leak, output bit released);
    who = -1; lat = -1; id = 1'b0; y = '0; stable = 1'b1; leak = 1'b0; released = 1'b0;
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
    bus.rsp_ready  = 1'b0;
    #1;
    if (bus.req0_ready && bus.req1_ready) who = 2;
    else if (bus.req0_ready) who = 0;
    else if (bus.req1_ready) who = 1;
    if (who < 0) begin
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.req0_a = scramble ? 32'd0 : $urandom; bus.req0_b = $urandom;
    bus.req1_a = $urandom;                    bus.req1_b = $urandom;
    for (int i = 0; i <= 40 && lat < 0; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (bus.req0_ready || bus.req1_ready) leak = 1'b1;
      if (bus.rsp_valid) lat = i;
    end
    if (lat < 0) begin
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      return;
    end
    id = bus.rsp_id;
    y  = bus.rsp_y;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk); #1;
      if (!bus.rsp_valid || bus.rsp_id !== id || bus.rsp_y !== y) stable = 1'b0;
      if (bus.req0_ready || bus.req1_ready) leak = 1'b1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    #1;
    released = !bus.rsp_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    tests++; if (bus.rsp_id !== 1'b0) begin fails++; $display("FAIL reset_rsp_id: got %b want 0", bus.rsp_id); end
    tests++; if (bus.rsp_y !== 64'd0) begin fails++; $display("FAIL reset_rsp_y: got %h want 0", bus.rsp_y); end
    rst = 1'b0;
    m_last = 1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int who, lat; logic id; logic [63:0] y; bit stable, leak, rel;
    run_txn(1'b1, 1'b0, 32'd1, 32'd3, 32'd0, 32'd0, 0, 1'b0, who, lat, id, y, stable, leak, rel);
    tests++; if (who !== 0) begin fails++; $display("FAIL single_grant: got %0d want 0", who); end
    tests++; if (lat !== MUL_CYCLES) begin fails++; $display("FAIL single_latency: got %0d want %0d", lat, MUL_CYCLES); end
    tests++; if (id !== 1'b0 || y !== 64'd3) begin fails++; $display("FAIL single_rsp: got id=%b y=%0d want id=0 y=3", id, y); end
    tests++; if (leak || !rel) begin fails++; $display("FAIL single_handshake: got leak=%b released=%b want 0/1", leak, rel); end
    m_last = 0;
  endtask

  task automatic test_simultaneous();
    int who, lat, ew; logic id; logic [63:0] y, ey; bit stable, leak, rel;
    for (int k = 0; k < 3; k++) begin
      ew = exp_winner(1'b1, 1'b1, m_last);
      ey = (ew == 0) ? 64'd8670 : 64'd45084;
      run_txn(1'b1, 1'b1, 32'd85, 32'd102, 32'd204, 32'd221, 0, 1'b0, who, lat, id, y, stable, leak, rel);
      tests++; if (who !== ew || id !== ew[0]) begin fails++; $display("FAIL simul_grant[%0d]: got grant=%0d id=%b want %0d", k, who, id, ew); end
      tests++; if (y !== ey) begin fails++; $display("FAIL simul_product[%0d]: got %0d want %0d", k, y, ey); end
      m_last = ew;
    end
  endtask

  task automatic test_starvation();
    int who, lat, ew; logic id; logic [63:0] y, ey; bit stable, leak, rel;
    int seq_bad;
    seq_bad = 0;
    for (int k = 0; k < 6; k++) begin
      ew = exp_winner(1'b1, 1'b1, m_last);
      ey = (ew == 0) ? 64'd28322 : 64'd21675;
      run_txn(1'b1, 1'b1, 32'd238, 32'd119, 32'd255, 32'd85, 0, 1'b0, who, lat, id, y, stable, leak, rel);
      tests++; if (id !== ew[0] || y !== ey) begin fails++; seq_bad++; $display("FAIL starve[%0d]: got id=%b y=%0d want id=%0d y=%0d", k, id, y, ew, ey); end
      m_last = ew;
    end
    tests++; if (seq_bad != 0) begin fails++; $display("FAIL starve_sequence: got %0d bad entries want 0", seq_bad); end
  endtask

  task automatic test_backpressure();
    int who, lat; logic id; logic [63:0] y; bit stable, leak, rel;
    run_txn(1'b0, 1'b1, 32'd0, 32'd0, 32'd170, 32'd170, 5, 1'b0, who, lat, id, y, stable, leak, rel);
    tests++; if (y !== 64'd28900 || id !== 1'b1) begin fails++; $display("FAIL bp_rsp: got id=%b y=%0d want id=1 y=28900", id, y); end
    tests++; if (!stable) begin fails++; $display("FAIL bp_hold: got unstable response want stable"); end
    tests++; if (leak) begin fails++; $display("FAIL bp_no_ready: got ready during stall want none"); end
    tests++; if (!rel) begin fails++; $display("FAIL bp_release: got rsp_valid=1 after rsp_ready want 0"); end
    m_last = 1;
  endtask

  task automatic test_max_hold();
    int who, lat; logic id; logic [63:0] y; bit stable, leak, rel;
    run_txn(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1, 1'b1, who, lat, id, y, stable, leak, rel);
    tests++; if (y !== 64'hFFFF_FFFE_0000_0001) begin fails++; $display("FAIL max_product: got %h want fffffffe00000001", y); end
    m_last = 0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 24; r++) begin
      int sel, mode, who, lat, ew, stall;
      bit v0, v1, stable, leak, rel;
      logic [31:0] a0, b0, a1, b1;
      logic id;
      logic [63:0] y, ey;
      sel  = $urandom_range(1, 3);
      v0   = sel[0];
      v1   = sel[1];
      mode = $urandom_range(0, 3);
      a0 = (mode == 0) ? 32'hFFFF_FFFF : $urandom;
      b0 = (mode == 0) ? 32'hFFFF_FFFF : $urandom;
      a1 = (mode == 1) ? 32'd0 : $urandom;
      b1 = $urandom;
      stall = $urandom_range(0, 3);
      ew = exp_winner(v0, v1, m_last);
      ey = (ew == 0) ? 64'(a0) * 64'(b0) : 64'(a1) * 64'(b1);
      run_txn(v0, v1, a0, b0, a1, b1, stall, 1'b0, who, lat, id, y, stable, leak, rel);
      tests++; if (who !== ew || id !== ew[0]) begin fails++; $display("FAIL rand_grant[%0d]: got grant=%0d id=%b want %0d", r, who, id, ew); end
      tests++; if (y !== ey) begin fails++; $display("FAIL rand_product[%0d]: got %h want %h", r, y, ey); end
      tests++; if (lat !== MUL_CYCLES || !stable || leak || !rel) begin
        fails++; $display("FAIL rand_timing[%0d]: got lat=%0d stable=%b leak=%b rel=%b want %0d/1/0/1", r, lat, stable, leak, rel, MUL_CYCLES);
      end
      m_last = ew;
    end
  endtask

`ifdef VEDIC_MUL_ARBITER_STATS_EN
  task automatic test_stats();
    int who, lat; logic id; logic [63:0] y; bit stable, leak, rel;
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    #1;
    tests++; if (gnt0_cnt !== 16'd0 || gnt1_cnt !== 16'd0) begin fails++; $display("FAIL stats_clear: got %0d/%0d want 0/0", gnt0_cnt, gnt1_cnt); end
    for (int k = 0; k < 5; k++) begin
      run_txn(k < 3, k >= 3, 32'd2, 32'd5, 32'd7, 32'd9, 0, 1'b0, who, lat, id, y, stable, leak, rel);
    end
    tests++; if (gnt0_cnt !== 16'd3 || gnt1_cnt !== 16'd2) begin fails++; $display("FAIL stats_count: got %0d/%0d want 3/2", gnt0_cnt, gnt1_cnt); end
    bus.req0_valid = 1'b1; bus.req0_a = 32'd4; bus.req0_b = 32'd4;
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0; bus.req0_valid = 1'b0;
    #1;
    tests++; if (gnt0_cnt !== 16'd0) begin fails++; $display("FAIL stats_clr_wins: got %0d want 0", gnt0_cnt); end
    bus.rsp_ready = 1'b1;
    repeat (MUL_CYCLES + 3) @(negedge clk);
    bus.rsp_ready = 1'b0;
    m_last = 0;
  endtask
`endif

  task automatic test_reset_mid();
    int who, lat; logic id; logic [63:0] y; bit stable, leak, rel, seen;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd85; bus.req0_b = 32'd221;
    #1;
    tests++; if (bus.req0_ready !== 1'b1) begin fails++; $display("FAIL rmid_accept: got ready=%b want 1", bus.req0_ready); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++; if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 1'b0 || bus.rsp_y !== 64'd0) begin
      fails++; $display("FAIL rmid_outputs: got v=%b id=%b y=%h want 0/0/0", bus.rsp_valid, bus.rsp_id, bus.rsp_y);
    end
`ifdef VEDIC_MUL_ARBITER_STATS_EN
    tests++; if (gnt0_cnt !== 16'd0 || gnt1_cnt !== 16'd0) begin fails++; $display("FAIL rmid_stats: got %0d/%0d want 0/0", gnt0_cnt, gnt1_cnt); end
`endif
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    tests++; if (seen) begin fails++; $display("FAIL rmid_stale: got rsp_valid after reset want none"); end
    m_last = 1;
    run_txn(1'b1, 1'b1, 32'd85, 32'd221, 32'd3, 32'd7, 0, 1'b0, who, lat, id, y, stable, leak, rel);
    tests++; if (who !== 0 || id !== 1'b0 || y !== 64'd18785) begin
      fails++; $display("FAIL rmid_tie: got grant=%0d id=%b y=%0d want 0/0/18785", who, id, y);
    end
    m_last = 0;
  endtask

  initial begin
`ifdef VEDIC_MUL_ARBITER_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_simultaneous();
    test_starvation();
    test_backpressure();
    test_max_hold();
    test_random();
`ifdef VEDIC_MUL_ARBITER_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
